// File: rtl/mmc1_mapper_gen_pkg.sv
// Shared constants and types for the MMC1-class mapper: register select codes,
// init values, mirroring and PRG mode codes, and the pending-write record.
package mmc1_mapper_gen_pkg;

  localparam logic [1:0] SEL_CTRL = 2'b00;
  localparam logic [1:0] SEL_CHR0 = 2'b01;
  localparam logic [1:0] SEL_CHR1 = 2'b10;
  localparam logic [1:0] SEL_PRG  = 2'b11;

  localparam logic [4:0] SHIFT_INIT = 5'b10000;
  localparam logic [4:0] CTRL_INIT  = 5'b01100;

  localparam logic [1:0] MIR_ONE_LO = 2'b00;
  localparam logic [1:0] MIR_ONE_HI = 2'b01;
  localparam logic [1:0] MIR_VERT   = 2'b10;
  localparam logic [1:0] MIR_HORZ   = 2'b11;

  localparam logic [1:0] PRG_FIX_LO = 2'b10;
  localparam logic [1:0] PRG_FIX_HI = 2'b11;

  typedef struct packed {
    logic       d7;
    logic       d0;
    logic [1:0] sel;
  } wr_req_t;

endpackage

// File: rtl/mmc1_mapper_gen_if.sv
// Cartridge-edge bus bundle: CPU/PPU inputs and bank/CE outputs of the mapper.
// SUROM_OUTER_BANK_EN adds the PRG_A18 outer-bank line.
interface mmc1_mapper_gen_if #(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 5
);
  logic                  CPU_M2, nCPU_ROMSEL, nCPU_RW;
  logic                  CPU_A14, CPU_A13, CPU_D7, CPU_D0;
  logic                  PPU_A12, PPU_A11, PPU_A10;
  logic [PRG_BANK_W-1:0] PRG_A;
  logic [CHR_BANK_W-1:0] CHR_A;
  logic                  CIRAM_A10, nPRG_CE, nWRAM_CE;
`ifdef SUROM_OUTER_BANK_EN
  logic                  PRG_A18;

  modport master (
    output CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
           PPU_A12, PPU_A11, PPU_A10,
    input  PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE, PRG_A18
  );
  modport slave (
    input  CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
           PPU_A12, PPU_A11, PPU_A10,
    output PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE, PRG_A18
  );
`else
  modport master (
    output CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
           PPU_A12, PPU_A11, PPU_A10,
    input  PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE
  );
  modport slave (
    input  CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
           PPU_A12, PPU_A11, PPU_A10,
    output PRG_A, CHR_A, CIRAM_A10, nPRG_CE, nWRAM_CE
  );
`endif
endinterface

// File: rtl/mmc1_mapper_gen_m2_sync.sv
// M2 synchroniser: SYNC_STAGES flop chain into the CLK domain plus one-cycle
// rise/fall pulses derived from the synchronised level.
module mmc1_m2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic m2_i,
  output logic m2_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], m2_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign m2_o   = sync_q[SYNC_STAGES-1];
  assign rise_o =  m2_o & ~prev_q;
  assign fall_o = ~m2_o &  prev_q;

endmodule

// File: rtl/mmc1_mapper_gen.sv
// MMC1-class mapper: oversampled CPU bus, serial register loads with RMW filter,
// combinational bank/CE/mirroring outputs. Optional macro: SUROM_OUTER_BANK_EN.
module mmc1_mapper_gen
  import mmc1_mapper_gen_pkg::*;
#(
  parameter int PRG_BANK_W   = 4,
  parameter int CHR_BANK_W   = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int WRAM_PRESENT = 1
) (
  input logic              CLK,
  input logic              RST,
  mmc1_mapper_gen_if.slave bus
);

  logic       m2_s, m2_fall, m2_rise_unused;
  logic [4:0] shift_q, shift_d, ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d, chr1_q, chr1_d, prg_q, prg_d;
  wr_req_t    pend_q, pend_d;
  logic       pend_v_q, pend_v_d, dbl_q, dbl_d;

  mmc1_m2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_m2_sync (
    .CLK    (CLK),
    .RST    (RST),
    .m2_i   (bus.CPU_M2),
    .m2_o   (m2_s),
    .rise_o (m2_rise_unused),
    .fall_o (m2_fall)
  );

  always_comb begin
    shift_d  = shift_q;
    ctrl_d   = ctrl_q;
    chr0_d   = chr0_q;
    chr1_d   = chr1_q;
    prg_d    = prg_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    dbl_d    = dbl_q;
    if (m2_s && !bus.nCPU_ROMSEL && !bus.nCPU_RW) begin
      pend_d.d7  = bus.CPU_D7;
      pend_d.d0  = bus.CPU_D0;
      pend_d.sel = {bus.CPU_A14, bus.CPU_A13};
      pend_v_d   = 1'b1;
    end
    // One commit per M2 cycle; a write right after a write cycle is the RMW echo.
    if (m2_fall) begin
      pend_v_d = 1'b0;
      dbl_d    = pend_v_q;
      if (pend_v_q && !dbl_q) begin
        if (pend_q.d7) begin
          shift_d = SHIFT_INIT;
          ctrl_d  = ctrl_q | CTRL_INIT;
        end else if (!shift_q[0]) begin
          shift_d = {pend_q.d0, shift_q[4:1]};
        end else begin
          shift_d = SHIFT_INIT;
          case (pend_q.sel)
            SEL_CTRL: ctrl_d = {pend_q.d0, shift_q[4:1]};
            SEL_CHR0: chr0_d = {pend_q.d0, shift_q[4:1]};
            SEL_CHR1: chr1_d = {pend_q.d0, shift_q[4:1]};
            default:  prg_d  = {pend_q.d0, shift_q[4:1]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q  <= SHIFT_INIT;
      ctrl_q   <= CTRL_INIT;
      chr0_q   <= '0;
      chr1_q   <= '0;
      prg_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      dbl_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      ctrl_q   <= ctrl_d;
      chr0_q   <= chr0_d;
      chr1_q   <= chr1_d;
      prg_q    <= prg_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      dbl_q    <= dbl_d;
    end
  end

  // Full 5-bit bank values are formed first and truncated to the port widths.
  logic [4:0] prg_full, chr_full, chr_sel;
  logic       wram_en;

  always_comb begin
    case (ctrl_q[3:2])
      PRG_FIX_LO: prg_full = bus.CPU_A14 ? prg_q : 5'b0;
      PRG_FIX_HI: prg_full = bus.CPU_A14 ? 5'b11111 : prg_q;
      default:    prg_full = {prg_q[4:1], bus.CPU_A14};
    endcase
    chr_sel  = (ctrl_q[4] && bus.PPU_A12) ? chr1_q : chr0_q;
    chr_full = ctrl_q[4] ? chr_sel : {chr0_q[4:1], bus.PPU_A12};
  end

  always_comb begin
    case (ctrl_q[1:0])
      MIR_ONE_LO: bus.CIRAM_A10 = 1'b0;
      MIR_ONE_HI: bus.CIRAM_A10 = 1'b1;
      MIR_VERT:   bus.CIRAM_A10 = bus.PPU_A10;
      default:    bus.CIRAM_A10 = bus.PPU_A11;
    endcase
  end

  assign wram_en       = ~prg_q[4] & (WRAM_PRESENT != 0);
  assign bus.PRG_A     = prg_full[PRG_BANK_W-1:0];
  assign bus.CHR_A     = chr_full[CHR_BANK_W-1:0];
  assign bus.nPRG_CE   = bus.nCPU_ROMSEL | ~bus.nCPU_RW;
  assign bus.nWRAM_CE  = ~(bus.CPU_M2 & bus.nCPU_ROMSEL & bus.CPU_A14 & bus.CPU_A13 & wram_en);
`ifdef SUROM_OUTER_BANK_EN
  assign bus.PRG_A18   = chr_sel[4];
`endif

  logic unused_bits;
  assign unused_bits = ^{prg_full, chr_full, chr_sel, m2_rise_unused};

endmodule
